sram_crc_scanner: RTL and testbench

- Sequential read-and-check engine that sits between the 32x1024 SRAM read port and the CRC-32/MPEG-2 consumer.
- On a start command it issues a burst of back-to-back SRAM reads over a word range, starting at a base address.
- It folds every returned word into a running CRC-32/MPEG-2 and reports the final CRC, a compare-match flag and a done pulse.
- Replaces the per-word, purely combinational CRC with a whole-region integrity check.

---
 rtl/sram_crc_scanner.sv | 189 ++++++++++++++++++
 tb/tb_sram_crc_scanner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_crc_scanner.sv
`default_nettype none
// ============================================================================
// Module   : sram_crc_scanner
// Brief    : Burst-reads a word range from a 32x1024 SRAM read port, folds
//            every returned word into a running CRC-32/MPEG-2 and reports the
//            final CRC, a golden-compare flag and a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sram_crc_scanner #(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          DATA_WIDTH   = 33,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] CRC_INIT     = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [31:0]           expected_crc,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           crc_out,
    output logic                  match
);

    localparam logic [31:0]         C_POLY    = 32'h04C1_1DB7;
    // Largest region that fits the address space (one full pass of the SRAM)
    localparam logic [ADDR_WIDTH:0] C_MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic [31:0]             r_expected;
    logic [31:0]             r_crc_acc;
    logic [31:0]             r_crc_out;
    logic                    r_match;
    // Valid shift pipeline: entry at the top bit, bit 0 flags returned data
    logic [READ_LATENCY-1:0] r_vpipe;

    logic [READ_LATENCY-1:0] w_vpipe_next;
    logic [ADDR_WIDTH:0]     w_len_sat;
    logic                    w_active;
    logic                    w_capture;
    logic                    w_drain_empty;
    logic [31:0]             w_crc_next;

    // One 32-bit word absorbed per call, bit 31 first, MSB-first LFSR form
    function automatic logic [31:0] crc32_mpeg2_word(input logic [31:0] crc_in,
                                                     input logic [31:0] word);
        logic [31:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ word[i]) begin
                c = {c[30:0], 1'b0} ^ C_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Only the low 32 data bits carry payload; the extra SRAM bits are dropped
    generate
        if (DATA_WIDTH > 32) begin : g_unused_dout_msb
            logic w_unused_dout_msb;
            assign w_unused_dout_msb = ^sram_dout[DATA_WIDTH-1:32];
        end
    endgenerate

    assign w_len_sat     = (length > C_MAX_LEN) ? C_MAX_LEN : length;
    assign w_active      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_capture     = r_vpipe[0] && w_active;
    // Nothing remains in flight once the word at the pipeline output is taken
    assign w_drain_empty = ((r_vpipe >> 1) == '0);
    assign w_crc_next    = w_capture ? crc32_mpeg2_word(r_crc_acc, sram_dout[31:0])
                                     : r_crc_acc;

    assign sram_csb  = (r_state != S_ISSUE);
    assign sram_web  = 1'b1;
    assign sram_addr = r_addr;
    assign busy      = w_active;
    assign done      = (r_state == S_FINISH);
    assign crc_out   = r_crc_out;
    assign match     = r_match;

    // Advance the valid pipeline; a new bit enters on every issued read
    always_comb begin
        w_vpipe_next                 = r_vpipe >> 1;
        w_vpipe_next[READ_LATENCY-1] = (r_state == S_ISSUE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (length == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_remaining == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_empty) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Address/count bookkeeping, CRC accumulation and result publication.
    // Results are published on the edge entering FINISH so that crc_out and
    // match are already final during the cycle done is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_expected  <= '0;
            r_crc_acc   <= '0;
            r_crc_out   <= '0;
            r_match     <= 1'b0;
            r_vpipe     <= '0;
        end else begin
            r_vpipe <= w_vpipe_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= w_len_sat;
                        r_expected  <= expected_crc;
                        r_crc_acc   <= CRC_INIT;
                        if (length == '0) begin
                            r_crc_out <= CRC_INIT;
                            r_match   <= (CRC_INIT == expected_crc);
                        end
                    end
                end
                S_ISSUE: begin
                    r_addr      <= r_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    r_crc_acc   <= w_crc_next;
                end
                S_DRAIN: begin
                    r_crc_acc <= w_crc_next;
                    if (w_drain_empty) begin
                        r_crc_out <= w_crc_next;
                        r_match   <= (w_crc_next == r_expected);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_crc_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_crc_scanner
// Brief    : Scoreboard bench for sram_crc_scanner with a behavioural SRAM
//            read port (one cycle latency) and a bit-serial CRC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_crc_scanner;

    localparam int AW = 10;
    localparam int DW = 33;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [31:0]   expected_crc;
    logic          sram_csb;
    logic          sram_web;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout = '0;
    logic          busy;
    logic          done;
    logic [31:0]   crc_out;
    logic          match;

    logic [DW-1:0] mem [0:1023];

    int            tests = 0;
    int            fails = 0;
    logic [32:0]   exp_q [$];

    always #5 clk = ~clk;

    sram_crc_scanner #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (1),
        .CRC_INIT     (32'hFFFF_FFFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .expected_crc (expected_crc),
        .sram_csb     (sram_csb),
        .sram_web     (sram_web),
        .sram_addr    (sram_addr),
        .sram_dout    (sram_dout),
        .busy         (busy),
        .done         (done),
        .crc_out      (crc_out),
        .match        (match)
    );

    // Behavioural SRAM read port, data valid the cycle after the address
    always @(posedge clk) begin
        if (!sram_csb) sram_dout <= mem[sram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Bit-serial reference: one data bit per step, word bit 31 first
    function automatic logic [31:0] model_crc(input int base, input int len);
        logic [31:0] c;
        logic [31:0] w;
        logic        fb;
        int          nw;
        c  = 32'hFFFF_FFFF;
        nw = (len > 1024) ? 1024 : len;
        for (int k = 0; k < nw; k++) begin
            w = mem[(base + k) % 1024][31:0];
            for (int b = 31; b >= 0; b--) begin
                fb = c[31] ^ w[b];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        return c;
    endfunction

    // Monitor: every done pulse pops one expected result from the scoreboard
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, required no done");
            end else begin
                e = exp_q.pop_front();
                check("crc_out", {32'h0, crc_out}, {32'h0, e[31:0]});
                check("match", {63'h0, match}, {63'h0, e[32]});
            end
        end
    end

    // Issue one scan, push its expected result, and check timing/addresses.
    // poke>0 pulses a second start in that cycle after acceptance.
    task automatic run_scan(input string nm, input logic [AW-1:0] base, input logic [AW:0] len,
                            input logic [31:0] golden, input logic [31:0] want_crc,
                            input logic want_match, input int poke);
        int            n;
        int            done_n;
        int            csb_n;
        int            busy_bad;
        int            addr_err;
        int            eff;
        logic [AW-1:0] a_exp;
        logic [AW-1:0] addrs [$];
        eff = (len > 11'd1024) ? 1024 : int'(len);
        @(negedge clk);
        start        = 1'b1;
        base_addr    = base;
        length       = len;
        expected_crc = golden;
        exp_q.push_back({want_match, want_crc});
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = base + 10'h155;
        done_n    = 0;
        csb_n     = 0;
        busy_bad  = 0;
        n         = 0;
        while (done_n == 0 && n < 3000) begin
            @(negedge clk);
            n++;
            if (start) start = 1'b0;
            if (n == poke) begin
                start     = 1'b1;
                base_addr = 10'h200;
                length    = 11'd3;
            end
            if (!sram_csb) begin
                csb_n++;
                addrs.push_back(sram_addr);
            end
            if (done) begin
                done_n = n;
                if (busy !== 1'b0) busy_bad++;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
        end
        if (start) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (done_n == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_done_timeout: got no done in %0d cycles, required done", nm, n);
        end else begin
            check({nm, "_done_cycle"}, 64'(done_n), (eff == 0) ? 64'd1 : 64'(eff + 2));
        end
        check({nm, "_csb_cycles"}, 64'(csb_n), 64'(eff));
        addr_err = 0;
        for (int i = 0; i < addrs.size(); i++) begin
            a_exp = base + i[AW-1:0];
            if (addrs[i] !== a_exp) addr_err++;
        end
        check({nm, "_addr_seq_errors"}, 64'(addr_err), 64'd0);
        check({nm, "_busy_errors"}, 64'(busy_bad), 64'd0);
    endtask

    initial begin
        logic [31:0] c4;
        logic [31:0] c8;
        logic [31:0] cd;
        logic [31:0] cw;
        logic [31:0] cs;
        int          late_done;

        for (int i = 0; i < 1024; i++) mem[i] = {1'($urandom), 32'($urandom)};
        mem[0] = {1'b1, 32'h3132_3334};
        mem[1] = {1'b1, 32'h3536_3738};
        mem[2] = {1'b0, 32'hDEAD_BEEF};
        mem[3] = {1'b1, 32'h0000_0000};
        mem[10'h3FE] = {1'b1, 32'h0102_0304};
        mem[10'h3FF] = {1'b0, 32'hA5A5_A5A5};

        rst_n        = 1'b0;
        start        = 1'b0;
        base_addr    = '0;
        length       = '0;
        expected_crc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'h0, busy}, 64'd0);
        check("rst_done", {63'h0, done}, 64'd0);
        check("rst_crc_out", {32'h0, crc_out}, 64'd0);
        check("rst_match", {63'h0, match}, 64'd0);
        check("rst_csb", {63'h0, sram_csb}, 64'd1);
        check("rst_web", {63'h0, sram_web}, 64'd1);
        check("rst_addr", {54'h0, sram_addr}, 64'd0);
        rst_n = 1'b1;

        // Empty region: seed comes straight back, no SRAM access
        run_scan("zero", 10'h000, 11'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);

        // Residue: appending the CRC of a region makes the CRC of the whole zero
        c4 = model_crc(0, 4);
        run_scan("res4", 10'h000, 11'd4, 32'h0000_0000, c4, (c4 == 32'h0), 0);
        mem[4] = {1'b1, c4};
        run_scan("res5", 10'h000, 11'd5, 32'h0000_0000, 32'h0000_0000, 1'b1, 0);

        // Throughput: eight back-to-back reads, done ten cycles after start
        c8 = model_crc(10'h010, 8);
        run_scan("len8", 10'h010, 11'd8, c8, c8, 1'b1, 0);

        // Wrong golden value, plus a start pulse in the middle of the scan
        run_scan("mism", 10'h000, 11'd4, c4 ^ 32'h1, c4, 1'b0, 2);

        // Start raised in the done cycle must not launch a new scan
        cd = model_crc(10'h020, 2);
        run_scan("donepoke", 10'h020, 11'd2, cd, cd, 1'b1, 4);
        @(negedge clk);
        check("donepoke_idle", {62'h0, busy, sram_csb}, 64'b01);

        // Address wraps from the top of the array to word 0
        cw = model_crc(10'h3FE, 4);
        run_scan("wrap", 10'h3FE, 11'd4, cw, cw, 1'b1, 0);

        // Oversized length saturates to one full pass of the array
        cs = model_crc(10'h005, 1024);
        run_scan("sat", 10'h005, 11'h7FF, cs, cs, 1'b1, 0);

        // Reset on the third issue cycle abandons the scan without a done
        @(negedge clk);
        start        = 1'b1;
        base_addr    = 10'h000;
        length       = 11'd8;
        expected_crc = 32'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_issuing", {63'h0, sram_csb}, 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", {63'h0, busy}, 64'd0);
        check("midrst_csb", {63'h0, sram_csb}, 64'd1);
        check("midrst_crc_out", {32'h0, crc_out}, 64'd0);
        check("midrst_match", {63'h0, match}, 64'd0);
        late_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) late_done++;
        end
        check("midrst_no_done", 64'(late_done), 64'd0);

        check("scoreboard_left", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
